nap_alarm_controller: RTL and testbench
=======================================

# nap_alarm_controller

Sequencing controller for the nap-alarm datapath. Latches the 24-bit BCD alarm time produced by the shortcut-setting path when `completeSetting` pulses, then compares it against the running clock. On a match it drives the buzzer and owns the ring / snooze / stop lifecycle, including a bounded snooze count and a ring timeout. It sits between the shortcut-setting block, the real-time clock counter and the buzzer/LED outputs.

## Interface
Parameters:
- `RING_SECONDS`, 60: tick count a ring lasts before auto-timeout.
- `SNOOZE_SECONDS`, 300: tick count of one snooze interval (max 511).
- `MAX_SNOOZE`, 3: number of snoozes accepted per alarm (max 3).

Ports:
- `clock` in 1: the single clock for the block.
- `reset` in 1: asynchronous, active-low.
- `tick_1hz` in 1: one-cycle pulse, once per second.
- `completeSetting` in 1: one-cycle pulse; `alarm_in` is valid on this cycle.
- `alarm_in` in 24: BCD time, laid out as hour_ten[23:20], hour_one[19:16], min_ten[15:12], min_one[11:8], sec_ten[7:4], sec_one[3:0].
- `now_in` in 24: current time, same layout.
- `stop` in 1: one-cycle pulse, user stop/cancel.
- `snooze` in 1: one-cycle pulse, user snooze.
- `alarm_time` out 24: latched alarm.
- `armed`, `ringing`, `snoozing` out 1: state flags.
- `buzzer` out 1: buzzer drive.
- `missed` out 1: sticky; ring timed out without a stop.
- `snooze_left` out 2: snoozes still available.

## Operation
States: IDLE, ARMED, RINGING, SNOOZE.

Priority per cycle, highest first: `stop` > `completeSetting` > `snooze` > match/tick.

- **stop**, any state: go to IDLE; clear `missed`; force `buzzer` to 0.
- **completeSetting**, any state:
  - Latch `alarm_in` into `alarm_time`.
  - Go to ARMED.
  - Set `snooze_left` to `MAX_SNOOZE`; clear `missed`.
- **ARMED**: when `now_in == alarm_time` (all 24 bits), go to RINGING.
  - On entry the ring counter loads `RING_SECONDS` and `buzzer` is set to 1.
- **RINGING**:
  - Each `tick_1hz` toggles `buzzer` and decrements the ring counter.
  - A tick arriving while the counter is 1 goes to IDLE and sets `missed`.
  - `snooze` with `snooze_left` > 0 goes to SNOOZE: load the snooze counter with `SNOOZE_SECONDS`, decrement `snooze_left`, set `buzzer` to 0.
  - `snooze` with `snooze_left` = 0 is ignored; ringing continues.
- **SNOOZE**: each tick decrements the snooze counter. A tick while the counter is 1 re-enters RINGING, with the ring counter reloaded and `buzzer` set to 1.
- **IDLE**: `buzzer` is 0; matches and ticks are ignored.
- Flags are decoded from the state register: `armed`=ARMED, `ringing`=RINGING, `snoozing`=SNOOZE.
- Counters are binary, sized to their parameter. They never wrap, because they reload on every state entry.

## Timing
- Reset values:
  - state IDLE
  - `alarm_time` 24'h000000
  - `buzzer` 0, `missed` 0, `armed`/`ringing`/`snoozing` 0
  - `snooze_left` 0
  - both counters 0
- All outputs are registered or decoded from registers; there is no input-to-output combinational path.
- Latency:
  - `completeSetting` at cycle N: `armed`=1 and `alarm_time` updated at N+1.
  - Match seen at cycle N: `ringing`=1 and `buzzer`=1 at N+1.
  - `stop` / `snooze` at N: outputs reflect the new state at N+1.
- Boundary cases:
  - Match on the same cycle as `completeSetting`: the new alarm wins, and comparison uses the new value from N+1.
  - `alarm_in` equal to `now_in` at latch time: rings at N+2.
  - `snooze` and the final ring tick on the same cycle: snooze wins, provided `snooze_left` > 0.
  - `stop` and `completeSetting` on the same cycle: IDLE, and `alarm_time` is unchanged.
  - Reset asserted mid-ring: immediate asynchronous return to the reset values.

## Structure
- Package `nap_pkg` holds:
  - the state enum `nap_state_t`
  - `TIME_W`=24
  - `TIME_ZERO`=24'h000000
  - the BCD digit field offsets shared with the setting and clock blocks
- Sub-module `tick_downcounter`: a loadable down-counter with parameterized width, `load`/`value`/`tick` inputs, and an `at_one` flag. It is instantiated twice, once for the ring counter and once for the snooze counter.
- The comparator and FSM are inline in `nap_alarm_controller`.

## Test plan
Tests run with small parameters (`RING_SECONDS`=3, `SNOOZE_SECONDS`=2, `MAX_SNOOZE`=1).

- **Set then match**: `completeSetting` with `alarm_in`=24'h070000, then drive `now_in` to 24'h070000 → `armed`=1 one cycle after the setting; `ringing`=1 and `buzzer`=1 one cycle after the match.
- **Ring timeout**: in RINGING, issue 3 ticks and no stop → `buzzer` sequence 1,0,1; after the 3rd tick, state IDLE with `missed`=1; a later `stop` clears `missed`.
- **Snooze exhaustion**: in RINGING, `snooze` → `snoozing`=1, `snooze_left`=0; 2 ticks later `ringing`=1 again; a second `snooze` is ignored (`ringing` stays 1).
- **Collisions**: `stop` and `completeSetting` on the same cycle → IDLE with `alarm_time` unchanged; match and `completeSetting` on the same cycle with a different `alarm_in` → ARMED, no ring.
- **Async reset**: drop `reset` mid-ring, between clock edges → all outputs go to their reset values before the next edge; after release, the block stays in IDLE until the next `completeSetting`.

Source files
------------

// File: rtl/nap_pkg.sv
// Shared types and constants for the nap-alarm datapath: controller state,
// BCD time layout and the time-compare helper.
package nap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RINGING = 2'd2,
      ST_SNOOZE  = 2'd3
   } nap_state_t;

   localparam int unsigned TIME_W = 24;
   localparam logic [TIME_W-1:0] TIME_ZERO = 24'h000000;

   localparam int unsigned DIGIT_W      = 4;
   localparam int unsigned HOUR_TEN_LSB = 20;
   localparam int unsigned HOUR_ONE_LSB = 16;
   localparam int unsigned MIN_TEN_LSB  = 12;
   localparam int unsigned MIN_ONE_LSB  = 8;
   localparam int unsigned SEC_TEN_LSB  = 4;
   localparam int unsigned SEC_ONE_LSB  = 0;

   // Full-width equality: every digit, seconds included, must agree.
   function automatic logic time_match(input logic [TIME_W-1:0] a,
                                       input logic [TIME_W-1:0] b);
      return (a == b);
   endfunction

endpackage

// File: rtl/tick_downcounter.sv
// Loadable down-counter stepped by a tick; holds at zero and flags the
// cycle it sits at one so the owner can act on the final tick.
module tick_downcounter
   import nap_pkg::*;
#(
   parameter int unsigned WIDTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   input  logic             tick_i,
   output logic             at_one_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: load has priority over a tick; zero is a floor.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = value_i;
      end else if (tick_i && (count_q != {WIDTH{1'b0}})) begin
         count_d = count_q - WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= {WIDTH{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign at_one_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/nap_alarm_controller.sv
// Nap-alarm sequencer: latches the set alarm, compares it with the running
// clock and owns the ring / snooze / stop lifecycle and buzzer drive.
module nap_alarm_controller
   import nap_pkg::*;
#(
   parameter int unsigned RING_SECONDS   = 60,
   parameter int unsigned SNOOZE_SECONDS = 300,
   parameter int unsigned MAX_SNOOZE     = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              tick_1hz,
   input  logic              completeSetting,
   input  logic [TIME_W-1:0] alarm_in,
   input  logic [TIME_W-1:0] now_in,
   input  logic              stop,
   input  logic              snooze,
   output logic [TIME_W-1:0] alarm_time,
   output logic              armed,
   output logic              ringing,
   output logic              snoozing,
   output logic              buzzer,
   output logic              missed,
   output logic [1:0]        snooze_left
);

   localparam int unsigned RING_W   = $clog2(RING_SECONDS + 1);
   localparam int unsigned SNOOZE_W = $clog2(SNOOZE_SECONDS + 1);

   nap_state_t        state_q, state_d;
   logic [TIME_W-1:0] alarm_q, alarm_d;
   logic              buzzer_q, buzzer_d;
   logic              missed_q, missed_d;
   logic [1:0]        snooze_left_q, snooze_left_d;

   logic match_s;
   logic ring_load_s, ring_tick_s, ring_at_one_s;
   logic snz_load_s, snz_tick_s, snz_at_one_s;
   logic snooze_ok_s;

   assign match_s     = time_match(now_in, alarm_q);
   assign snooze_ok_s = snooze && (snooze_left_q != 2'd0);
   assign ring_tick_s = tick_1hz && (state_q == ST_RINGING);
   assign snz_tick_s  = tick_1hz && (state_q == ST_SNOOZE);

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: stop beats a new setting, which beats snooze and tick/match.
   always_comb begin
      state_d = state_q;
      if (stop) begin
         state_d = ST_IDLE;
      end else if (completeSetting) begin
         state_d = ST_ARMED;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_ARMED: begin
               if (match_s) state_d = ST_RINGING;
               else         state_d = ST_ARMED;
            end
            ST_RINGING: begin
               if (snooze_ok_s)                      state_d = ST_SNOOZE;
               else if (ring_tick_s && ring_at_one_s) state_d = ST_IDLE;
               else                                   state_d = ST_RINGING;
            end
            ST_SNOOZE: begin
               if (snz_tick_s && snz_at_one_s) state_d = ST_RINGING;
               else                            state_d = ST_SNOOZE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath next values, keyed off the transition chosen above.
   always_comb begin
      alarm_d       = alarm_q;
      buzzer_d      = buzzer_q;
      missed_d      = missed_q;
      snooze_left_d = snooze_left_q;
      if (stop) begin
         buzzer_d = 1'b0;
         missed_d = 1'b0;
      end else if (completeSetting) begin
         alarm_d       = alarm_in;
         buzzer_d      = 1'b0;
         missed_d      = 1'b0;
         snooze_left_d = 2'(MAX_SNOOZE);
      end else begin
         case (state_q)
            ST_IDLE: buzzer_d = 1'b0;
            ST_ARMED: begin
               if (match_s) buzzer_d = 1'b1;
               else         buzzer_d = 1'b0;
            end
            ST_RINGING: begin
               if (snooze_ok_s) begin
                  buzzer_d      = 1'b0;
                  snooze_left_d = snooze_left_q - 2'd1;
               end else if (ring_tick_s && ring_at_one_s) begin
                  buzzer_d = 1'b0;
                  missed_d = 1'b1;
               end else if (ring_tick_s) begin
                  buzzer_d = ~buzzer_q;
               end else begin
                  buzzer_d = buzzer_q;
               end
            end
            ST_SNOOZE: begin
               if (snz_tick_s && snz_at_one_s) buzzer_d = 1'b1;
               else                            buzzer_d = 1'b0;
            end
            default: buzzer_d = 1'b0;
         endcase
      end
   end

   // Counters reload on every entry into their owning state.
   assign ring_load_s = (state_d == ST_RINGING) && (state_q != ST_RINGING);
   assign snz_load_s  = (state_d == ST_SNOOZE) && (state_q != ST_SNOOZE);

   // Datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         alarm_q       <= TIME_ZERO;
         buzzer_q      <= 1'b0;
         missed_q      <= 1'b0;
         snooze_left_q <= 2'd0;
      end else begin
         alarm_q       <= alarm_d;
         buzzer_q      <= buzzer_d;
         missed_q      <= missed_d;
         snooze_left_q <= snooze_left_d;
      end
   end

   tick_downcounter #(.WIDTH(RING_W)) u_ring_cnt (
      .clock    (clock),
      .reset    (reset),
      .load_i   (ring_load_s),
      .value_i  (RING_W'(RING_SECONDS)),
      .tick_i   (ring_tick_s),
      .at_one_o (ring_at_one_s)
   );

   tick_downcounter #(.WIDTH(SNOOZE_W)) u_snooze_cnt (
      .clock    (clock),
      .reset    (reset),
      .load_i   (snz_load_s),
      .value_i  (SNOOZE_W'(SNOOZE_SECONDS)),
      .tick_i   (snz_tick_s),
      .at_one_o (snz_at_one_s)
   );

   assign alarm_time  = alarm_q;
   assign buzzer      = buzzer_q;
   assign missed      = missed_q;
   assign snooze_left = snooze_left_q;
   assign armed       = (state_q == ST_ARMED);
   assign ringing     = (state_q == ST_RINGING);
   assign snoozing    = (state_q == ST_SNOOZE);

endmodule

// File: tb/tb_nap_alarm_controller.sv
// Directed bench for nap_alarm_controller with small ring/snooze parameters:
// a vector table for the lifecycle plus hand sequences for reset behaviour.
module tb_nap_alarm_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        tick_1hz, completeSetting, stop, snooze;
   logic [23:0] alarm_in, now_in, alarm_time;
   logic        armed, ringing, snoozing, buzzer, missed;
   logic [1:0]  snooze_left;

   int total = 0;
   int bad   = 0;

   nap_alarm_controller #(
      .RING_SECONDS(3), .SNOOZE_SECONDS(2), .MAX_SNOOZE(1)
   ) dut (
      .clock(clock), .reset(reset), .tick_1hz(tick_1hz),
      .completeSetting(completeSetting), .alarm_in(alarm_in), .now_in(now_in),
      .stop(stop), .snooze(snooze), .alarm_time(alarm_time), .armed(armed),
      .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer), .missed(missed),
      .snooze_left(snooze_left)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        cs;
      logic [23:0] ain;
      logic [23:0] now;
      logic        stp;
      logic        snz;
      logic        tck;
      logic        e_armed;
      logic        e_ring;
      logic        e_snz;
      logic        e_buz;
      logic        e_miss;
      logic [1:0]  e_sl;
      logic [23:0] e_alarm;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic cs, input logic [23:0] ain, input logic [23:0] now,
                               input logic stp, input logic snz, input logic tck,
                               input logic ea, input logic er, input logic es, input logic eb,
                               input logic em, input logic [1:0] esl, input logic [23:0] eal);
      vec_t v;
      v.cs = cs; v.ain = ain; v.now = now; v.stp = stp; v.snz = snz; v.tck = tck;
      v.e_armed = ea; v.e_ring = er; v.e_snz = es; v.e_buz = eb; v.e_miss = em;
      v.e_sl = esl; v.e_alarm = eal;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [23:0] act, input logic [23:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step=%0d got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic ea, input logic er, input logic es,
                          input logic eb, input logic em, input logic [1:0] esl,
                          input logic [23:0] eal);
      chk("armed",       idx, {23'd0, armed},       {23'd0, ea});
      chk("ringing",     idx, {23'd0, ringing},     {23'd0, er});
      chk("snoozing",    idx, {23'd0, snoozing},    {23'd0, es});
      chk("buzzer",      idx, {23'd0, buzzer},      {23'd0, eb});
      chk("missed",      idx, {23'd0, missed},      {23'd0, em});
      chk("snooze_left", idx, {22'd0, snooze_left}, {22'd0, esl});
      chk("alarm_time",  idx, alarm_time,           eal);
   endtask

   // Inputs are applied on the falling edge, held for one rising edge, then sampled.
   task automatic step(input logic cs, input logic [23:0] ain, input logic [23:0] now,
                       input logic stp, input logic snz, input logic tck);
      completeSetting = cs; alarm_in = ain; now_in = now;
      stop = stp; snooze = snz; tick_1hz = tck;
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b0;
      tick_1hz = 1'b0; completeSetting = 1'b0; stop = 1'b0; snooze = 1'b0;
      alarm_in = 24'h000000; now_in = 24'h000000;
      #1;
      chk_all(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 24'h000000);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      step(1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);
      chk_all(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 24'h000000);

      //            cs    ain         now         stp   snz   tck   arm   ring  snz   buz   miss  sl    alarm
      vecs.push_back(mk(1'b1, 24'h070000, 24'h065959, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h070000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h065959, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h070000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h070000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 24'h070000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h070001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 24'h070000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h070002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 24'h070000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h070002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 24'h070000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h070003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 24'h070000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h070000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 24'h070000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h070004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h070000));
      // snooze exhaustion
      vecs.push_back(mk(1'b1, 24'h080000, 24'h070005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h080000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h080000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 24'h080000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h080001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 24'h080000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h080002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 24'h080000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h080003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 24'h080000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h080003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 24'h080000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h080004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 24'h080000));
      // snooze on the final ring tick
      vecs.push_back(mk(1'b1, 24'h090000, 24'h080005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h090000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h090000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 24'h090000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h090001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 24'h090000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h090002, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 24'h090000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h090003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 24'h090000));
      // stop + completeSetting: stop wins, alarm unchanged
      vecs.push_back(mk(1'b1, 24'h123456, 24'h090004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 24'h090000));
      // match + completeSetting with a different alarm: new alarm, no ring
      vecs.push_back(mk(1'b1, 24'h100000, 24'h090005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h100000));
      vecs.push_back(mk(1'b1, 24'h110000, 24'h100000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h110000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h100000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h110000));
      // alarm equal to now at latch time: rings two cycles later
      vecs.push_back(mk(1'b1, 24'h120000, 24'h120000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h120000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h120000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 24'h120000));
      vecs.push_back(mk(1'b0, 24'h000000, 24'h120001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h120000));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].cs, vecs[i].ain, vecs[i].now, vecs[i].stp, vecs[i].snz, vecs[i].tck);
         chk_all(i + 1, vecs[i].e_armed, vecs[i].e_ring, vecs[i].e_snz, vecs[i].e_buz,
                 vecs[i].e_miss, vecs[i].e_sl, vecs[i].e_alarm);
      end

      // Asynchronous reset in the middle of a ring, between clock edges.
      step(1'b1, 24'h130000, 24'h000000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 24'h000000, 24'h130000, 1'b0, 1'b0, 1'b0);
      chk_all(100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 24'h130000);
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk_all(101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 24'h000000);
      @(negedge clock);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b1);
         chk_all(102 + k, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 24'h000000);
      end
      step(1'b1, 24'h140000, 24'h000000, 1'b0, 1'b0, 1'b0);
      chk_all(105, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h140000);
      step(1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0);
      chk_all(106, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 24'h140000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
